// File: rtl/lv_ow_adc_rsp.sv
// ADC request responder: sends one ADC-read command frame on the one-wire TX link and acks ctrl fsm with the reply status.
// Optional feature macro OW_ADC_RETRY_EN: retry a failed attempt up to RETRY_NUM times before acking with an error.
module lv_ow_adc_rsp #(
    parameter logic [7:0]  ADC_CMD     = 8'h5A,
    parameter int unsigned ADC_DATA_W  = 16,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned RETRY_NUM   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ow_comm_en,
    input  logic                  i_fsm_ow_ctrl_req_adc,
    output logic                  o_ow_ctrl_fsm_ack_adc,
    output logic                  o_ow_ctrl_fsm_ack_adc_status,
    output logic                  o_ow_tx_vld,
    output logic [7:0]            o_ow_tx_cmd,
    input  logic                  i_ow_tx_rdy,
    input  logic                  i_ow_rx_vld,
    input  logic                  i_ow_rx_err,
    input  logic [ADC_DATA_W-1:0] i_ow_rx_data,
    output logic [ADC_DATA_W-1:0] o_adc_data,
    output logic                  o_adc_data_vld
);

    localparam int unsigned TO_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_CNT_W-1:0] TO_MAX  = TO_CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [TO_CNT_W-1:0]     to_cnt_q, to_cnt_d;
    logic                    ack_q, ack_d;
    logic                    ack_status_q, ack_status_d;
    logic                    tx_vld_q, tx_vld_d;
    logic [7:0]              tx_cmd_q, tx_cmd_d;
    logic [ADC_DATA_W-1:0]   adc_data_q, adc_data_d;
    logic                    adc_data_vld_q, adc_data_vld_d;
    logic                    attempt_fail;

`ifdef OW_ADC_RETRY_EN
    localparam int unsigned RTY_CNT_W = (RETRY_NUM > 0) ? $clog2(RETRY_NUM + 1) : 1;
    localparam logic [RTY_CNT_W-1:0] RTY_MAX = RTY_CNT_W'(RETRY_NUM);
    logic [RTY_CNT_W-1:0]    rty_cnt_q, rty_cnt_d;
`endif

    always_comb begin
        state_d        = state_q;
        to_cnt_d       = to_cnt_q;
        ack_d          = 1'b0;
        ack_status_d   = 1'b0;
        tx_vld_d       = tx_vld_q;
        tx_cmd_d       = tx_cmd_q;
        adc_data_d     = adc_data_q;
        adc_data_vld_d = 1'b0;
        attempt_fail   = 1'b0;
`ifdef OW_ADC_RETRY_EN
        rty_cnt_d      = rty_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_fsm_ow_ctrl_req_adc) begin
                    if (i_ow_comm_en) begin
                        state_d  = ST_SEND;
                        tx_vld_d = 1'b1;
                        tx_cmd_d = ADC_CMD;
`ifdef OW_ADC_RETRY_EN
                        rty_cnt_d = '0;
`endif
                    end else begin
                        state_d      = ST_ACK;
                        ack_d        = 1'b1;
                        ack_status_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                // RX pulses here are stale traffic and deliberately ignored.
                if (!i_ow_comm_en) begin
                    state_d      = ST_ACK;
                    ack_d        = 1'b1;
                    ack_status_d = 1'b1;
                    tx_vld_d     = 1'b0;
                    tx_cmd_d     = 8'h00;
                end else if (i_ow_tx_rdy) begin
                    state_d  = ST_WAIT;
                    tx_vld_d = 1'b0;
                    tx_cmd_d = 8'h00;
                    to_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (!i_ow_comm_en) begin
                    state_d      = ST_ACK;
                    ack_d        = 1'b1;
                    ack_status_d = 1'b1;
                end else if (i_ow_rx_vld && !i_ow_rx_err) begin
                    state_d        = ST_ACK;
                    ack_d          = 1'b1;
                    adc_data_d     = i_ow_rx_data;
                    adc_data_vld_d = 1'b1;
                end else if (i_ow_rx_vld || (to_cnt_q == TO_LAST)) begin
                    attempt_fail = 1'b1;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (attempt_fail) begin
`ifdef OW_ADC_RETRY_EN
            if (rty_cnt_q < RTY_MAX) begin
                rty_cnt_d = rty_cnt_q + 1'b1;
                state_d   = ST_SEND;
                tx_vld_d  = 1'b1;
                tx_cmd_d  = ADC_CMD;
            end else
`endif
            begin
                state_d      = ST_ACK;
                ack_d        = 1'b1;
                ack_status_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            to_cnt_q       <= '0;
            ack_q          <= 1'b0;
            ack_status_q   <= 1'b0;
            tx_vld_q       <= 1'b0;
            tx_cmd_q       <= 8'h00;
            adc_data_q     <= '0;
            adc_data_vld_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            to_cnt_q       <= to_cnt_d;
            ack_q          <= ack_d;
            ack_status_q   <= ack_status_d;
            tx_vld_q       <= tx_vld_d;
            tx_cmd_q       <= tx_cmd_d;
            adc_data_q     <= adc_data_d;
            adc_data_vld_q <= adc_data_vld_d;
        end
    end

`ifdef OW_ADC_RETRY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rty_cnt_q <= '0;
        end else begin
            rty_cnt_q <= rty_cnt_d;
        end
    end
`endif

    assign o_ow_ctrl_fsm_ack_adc        = ack_q;
    assign o_ow_ctrl_fsm_ack_adc_status = ack_status_q;
    assign o_ow_tx_vld                  = tx_vld_q;
    assign o_ow_tx_cmd                  = tx_cmd_q;
    assign o_adc_data                   = adc_data_q;
    assign o_adc_data_vld               = adc_data_vld_q;

endmodule

// File: tb/tb_lv_ow_adc_rsp.sv
// Directed table-driven bench for lv_ow_adc_rsp; expectations follow OW_ADC_RETRY_EN when defined.
module tb_lv_ow_adc_rsp;

    localparam int TO     = 1024;
    localparam int BUDGET = 5000;
`ifdef OW_ADC_RETRY_EN
    localparam bit RTY = 1'b1;
`else
    localparam bit RTY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        comm_en;
    logic        req;
    logic        ack;
    logic        ack_status;
    logic        tx_vld;
    logic [7:0]  tx_cmd;
    logic        tx_rdy;
    logic        rx_vld;
    logic        rx_err;
    logic [15:0] rx_data;
    logic [15:0] adc_data;
    logic        adc_data_vld;

    always #5 clk = ~clk;

    lv_ow_adc_rsp dut (
        .i_clk                        (clk),
        .i_rst                        (rst),
        .i_ow_comm_en                 (comm_en),
        .i_fsm_ow_ctrl_req_adc        (req),
        .o_ow_ctrl_fsm_ack_adc        (ack),
        .o_ow_ctrl_fsm_ack_adc_status (ack_status),
        .o_ow_tx_vld                  (tx_vld),
        .o_ow_tx_cmd                  (tx_cmd),
        .i_ow_tx_rdy                  (tx_rdy),
        .i_ow_rx_vld                  (rx_vld),
        .i_ow_rx_err                  (rx_err),
        .i_ow_rx_data                 (rx_data),
        .o_adc_data                   (adc_data),
        .o_adc_data_vld               (adc_data_vld)
    );

    typedef struct {
        string       name;
        bit          ce;
        int          rdy_wait;
        bit          rx_in_send;
        int          rx_lat;
        int          n_err;
        logic [15:0] data;
        int          drop_at;
        bit          exp_status;
        int          exp_frames;
        logic [15:0] exp_adc;
        int          exp_wait;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(string name, bit ce, int rdy_wait, bit rx_in_send, int rx_lat,
                                int n_err, logic [15:0] data, int drop_at, bit exp_status,
                                int exp_frames, logic [15:0] exp_adc, int exp_wait);
        vec_t v;
        v.name = name; v.ce = ce; v.rdy_wait = rdy_wait; v.rx_in_send = rx_in_send;
        v.rx_lat = rx_lat; v.n_err = n_err; v.data = data; v.drop_at = drop_at;
        v.exp_status = exp_status; v.exp_frames = exp_frames; v.exp_adc = exp_adc;
        v.exp_wait = exp_wait;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int  win, frames, hold, max_hold, since, first_ack, n_ends, wait_bad, stray_vld, extra;
        bit  got;
        logic st, dv;
        logic [15:0] ad;
        frames = 0; hold = 0; max_hold = 0; since = -1; first_ack = -1;
        n_ends = 0; wait_bad = 0; stray_vld = 0; extra = 0; got = 1'b0;
        st = 1'b0; dv = 1'b0; ad = '0;
        req = 1'b1; comm_en = v.ce; tx_rdy = 1'b0;
        for (win = 1; win <= BUDGET && !got; win++) begin
            tick();
            rx_vld = 1'b0; rx_err = 1'b0;
            if (since >= 0) since++;
            if (ack) begin
                got = 1'b1; first_ack = win;
                st = ack_status; dv = adc_data_vld; ad = adc_data;
                if (since >= 0) begin
                    n_ends++;
                    if (since - 1 != v.exp_wait) wait_bad++;
                    since = -1;
                end
                req = 1'b0;
            end else if (adc_data_vld) begin
                stray_vld++;
            end
            if (tx_vld) begin
                if (since >= 0) begin
                    n_ends++;
                    if (since - 1 != v.exp_wait) wait_bad++;
                    since = -1;
                end
                hold++;
                if (tx_cmd !== 8'h5A) extra++;
                if (v.rx_in_send && hold == 2) begin
                    rx_vld = 1'b1; rx_data = 16'h7777;
                end
                if (hold > v.rdy_wait) begin
                    tx_rdy = 1'b1; frames++; since = 0;
                    if (hold > max_hold) max_hold = hold;
                end else begin
                    tx_rdy = 1'b0;
                end
            end else begin
                tx_rdy = 1'b0; hold = 0;
            end
            if (v.rx_lat > 0 && since == v.rx_lat) begin
                rx_vld  = 1'b1;
                rx_err  = (frames <= v.n_err);
                rx_data = rx_err ? 16'hDEAD : v.data;
            end
            if (since >= 0 && since == v.drop_at) comm_en = 1'b0;
        end
        check({v.name, ".ack_seen"}, 32'(got), 32'd1);
        check({v.name, ".status"}, 32'(st), 32'(v.exp_status));
        check({v.name, ".data_vld"}, 32'(dv), 32'(!v.exp_status));
        check({v.name, ".adc_data"}, 32'(ad), 32'(v.exp_adc));
        check({v.name, ".frames"}, 32'(frames), 32'(v.exp_frames));
        check({v.name, ".tx_cmd_bad"}, 32'(extra), 32'd0);
        check({v.name, ".stray_vld"}, 32'(stray_vld), 32'd0);
        if (v.exp_frames > 0) check({v.name, ".tx_hold"}, 32'(max_hold), 32'(v.rdy_wait + 1));
        if (!v.ce) check({v.name, ".ack_latency_le2"}, 32'(first_ack <= 2), 32'd1);
        if (v.exp_wait > 0) begin
            check({v.name, ".wait_ends"}, 32'(n_ends), 32'(v.exp_frames));
            check({v.name, ".wait_len_bad"}, 32'(wait_bad), 32'd0);
        end
        tx_rdy = 1'b0; rx_vld = 1'b0; rx_err = 1'b0; comm_en = 1'b1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack || adc_data_vld || tx_vld) extra++;
        end
        check({v.name, ".quiet_after_ack"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int seen;
        int quiet;
        rst = 1'b1; comm_en = 1'b1; req = 1'b0; tx_rdy = 1'b0;
        rx_vld = 1'b0; rx_err = 1'b0; rx_data = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset.ack", 32'(ack), 32'd0);
        check("reset.status", 32'(ack_status), 32'd0);
        check("reset.tx_vld", 32'(tx_vld), 32'd0);
        check("reset.tx_cmd", 32'(tx_cmd), 32'h00);
        check("reset.adc_data", 32'(adc_data), 32'h0);
        check("reset.data_vld", 32'(adc_data_vld), 32'd0);

        vecs.push_back(mk("basic",     1, 0, 0, 3,  0, 16'h1234, -1, 0, 1, 16'h1234, 0));
        vecs.push_back(mk("stall",     1, 5, 1, 2,  0, 16'h00FF, -1, 0, 1, 16'h00FF, 0));
        vecs.push_back(mk("err_retry", 1, 1, 0, 4,  1, 16'hABCD, -1, !RTY, RTY ? 2 : 1,
                          RTY ? 16'hABCD : 16'h00FF, 0));
        vecs.push_back(mk("err_all",   1, 0, 0, 2,  9, 16'h5555, -1, 1, RTY ? 3 : 1,
                          RTY ? 16'hABCD : 16'h00FF, 0));
        vecs.push_back(mk("comm_off",  0, 0, 0, 0,  0, 16'h0000, -1, 1, 0,
                          RTY ? 16'hABCD : 16'h00FF, 0));
        vecs.push_back(mk("drop_wait", 1, 0, 0, 0,  0, 16'h0000,  5, 1, 1,
                          RTY ? 16'hABCD : 16'h00FF, 0));
        vecs.push_back(mk("timeout",   1, 0, 0, 0,  0, 16'h0000, -1, 1, RTY ? 3 : 1,
                          RTY ? 16'hABCD : 16'h00FF, TO));
        vecs.push_back(mk("late_ok",   1, 0, 0, TO, 0, 16'hBEEF, -1, 0, 1, 16'hBEEF, 0));
        vecs.push_back(mk("quick",     1, 2, 0, 1,  0, 16'h0001, -1, 0, 1, 16'h0001, 0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while waiting for the reply: no ack, everything back to reset values.
        req = 1'b1; comm_en = 1'b1; seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (tx_vld) begin
                tx_rdy = 1'b1; seen = 1;
            end
        end
        check("rst_wait.tx_seen", 32'(seen), 32'd1);
        tick();
        tx_rdy = 1'b0; req = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wait.ack", 32'(ack), 32'd0);
        check("rst_wait.tx_vld", 32'(tx_vld), 32'd0);
        check("rst_wait.tx_cmd", 32'(tx_cmd), 32'h00);
        check("rst_wait.adc_data", 32'(adc_data), 32'h0);
        check("rst_wait.data_vld", 32'(adc_data_vld), 32'd0);
        check("rst_wait.status", 32'(ack_status), 32'd0);
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            rx_vld = (i == 1); rx_data = 16'h9999;
            if (ack || adc_data_vld || tx_vld) quiet++;
        end
        rx_vld = 1'b0;
        check("rst_wait.no_ack", 32'(quiet), 32'd0);

        run_vec(mk("after_rst", 1, 0, 0, 2, 0, 16'h4321, -1, 0, 1, 16'h4321, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
